// File: rtl/cla_pipe_alu_adder_if.sv
// Operand/result bundle for the pipelined CLA adder: valid/ready on both sides.
// slave = the adder, master = the producer/consumer driving it.
interface cla_pipe_alu_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, sub, sat, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, sub, sat, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/cla_pipe_alu_adder.sv
// Two-stage group-CLA add/sub with signed saturation and flags; result 2 cycles after accept.
// Stage 1 holds P/G and group terms, stage 2 holds the result; bubbles collapse, in_ready follows out_ready.
module cla_pipe_alu_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cla_pipe_alu_adder_if.slave  bus
);
  localparam int NG  = WIDTH / GROUP;
  localparam int MSB = WIDTH - 1;

  // Group generate as an explicit sum of products: G[i] & P[GROUP-1:i+1].
  function automatic logic grp_gen(input logic [GROUP-1:0] p, input logic [GROUP-1:0] g);
    logic             gen;
    logic [GROUP-1:0] pmask;
    gen = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      pmask = p | ((GROUP'(1) << (i + 1)) - GROUP'(1));
      gen   = gen | (g[i] & (&pmask));
    end
    return gen;
  endfunction

  logic             v1_q, v1_d, v2_q, v2_d;
  logic             s2_load, in_rdy, in_acc;
  logic [WIDTH-1:0] beff_d, p_d, g_d;
  logic [NG-1:0]    pg_d, gg_d;
  logic [WIDTH-1:0] a1_q, beff1_q, p1_q, g1_q;
  logic [NG-1:0]    pg1_q, gg1_q;
  logic             cin1_q, sat1_q;
  logic [NG:0]      cgrp;
  logic             c_run;
  logic [WIDTH-1:0] cbit, raw_d, sum_d, sum_q;
  logic             cout_d, ovf_d, cout_q, ovf_q, zero_q, neg_q;

  assign s2_load = v1_q & (~v2_q | bus.out_ready);
  assign in_rdy  = ~v1_q | s2_load;
  assign in_acc  = bus.in_valid & in_rdy;
  assign v1_d    = in_acc ? 1'b1 : (s2_load ? 1'b0 : v1_q);
  assign v2_d    = s2_load ? 1'b1 : (bus.out_ready ? 1'b0 : v2_q);

  always_comb begin
    beff_d = bus.sub ? ~bus.b : bus.b;
    p_d    = bus.a | beff_d;
    g_d    = bus.a & beff_d;
    pg_d   = '0;
    gg_d   = '0;
    for (int g = 0; g < NG; g++) begin
      pg_d[g] = &p_d[g*GROUP +: GROUP];
      gg_d[g] = grp_gen(p_d[g*GROUP +: GROUP], g_d[g*GROUP +: GROUP]);
    end
  end

  // Stage-1 datapath carries no reset; v1_q qualifies it.
  always_ff @(posedge clk_i) begin
    if (in_acc) begin
      a1_q    <= bus.a;
      beff1_q <= beff_d;
      cin1_q  <= bus.sub;
      sat1_q  <= bus.sat;
      p1_q    <= p_d;
      g1_q    <= g_d;
      pg1_q   <= pg_d;
      gg1_q   <= gg_d;
    end
  end

  always_comb begin
    cgrp    = '0;
    cbit    = '0;
    c_run   = 1'b0;
    cgrp[0] = cin1_q;
    for (int g = 0; g < NG; g++) begin
      cgrp[g+1] = gg1_q[g] | (pg1_q[g] & cgrp[g]);
      c_run     = cgrp[g];
      for (int j = 0; j < GROUP; j++) begin
        cbit[g*GROUP+j] = c_run;
        c_run           = g1_q[g*GROUP+j] | (p1_q[g*GROUP+j] & c_run);
      end
    end
    raw_d  = a1_q ^ beff1_q ^ cbit;
    cout_d = cgrp[NG];
    ovf_d  = (a1_q[MSB] == beff1_q[MSB]) & (raw_d[MSB] != a1_q[MSB]);
    sum_d  = raw_d;
    if (sat1_q && ovf_d) begin
      sum_d = a1_q[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (s2_load) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= (sum_d == '0);
        neg_q  <= sum_d[MSB];
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = v2_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
endmodule

// File: tb/tb_cla_pipe_alu_adder.sv
// Bench for cla_pipe_alu_adder: integer-arithmetic reference queue plus directed literal vectors.
module tb_cla_pipe_alu_adder;
  localparam int W = 16;
  localparam int G = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  cla_pipe_alu_adder_if #(.WIDTH(W)) bus();

  cla_pipe_alu_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic sub, logic sat);
    exp_t   e;
    longint sa    = longint'($signed(a));
    longint sb    = longint'($signed(b));
    longint ua    = longint'(a);
    longint ub    = longint'(b);
    longint ideal = sub ? sa - sb : sa + sb;
    longint smax  = (longint'(1) << (W - 1)) - 1;
    longint smin  = -(longint'(1) << (W - 1));
    e.ovf  = (ideal > smax) || (ideal < smin);
    e.cout = sub ? (ua >= ub) : (ua + ub > (longint'(1) << W) - 1);
    e.sum  = W'(ideal);
    if (sat && e.ovf) e.sum = (ideal > 0) ? W'(smax) : W'(smin);
    e.zero = (e.sum == '0);
    e.neg  = e.sum[W-1];
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t dut_out();
    exp_t o;
    o.sum  = bus.sum;
    o.cout = bus.cout;
    o.ovf  = bus.ovf;
    o.zero = bus.zero;
    o.neg  = bus.neg;
    return o;
  endfunction

  // Scoreboard: occupancy rules and in-order results, checked every cycle out of reset.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      chk("in_ready_rule", 32'(bus.in_ready), 32'(!(q.size() == 2 && !bus.out_ready)));
      if (q.size() == 2) chk("out_valid_full", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("out_valid_when_empty", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("model_result", 32'(dut_out()), 32'(q[0]));
          if (bus.out_ready) void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.sub, bus.sat));
    end
  end

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 two cycles after the accept.
  task automatic one(string nm, logic [W-1:0] a, logic [W-1:0] b, logic sub, logic sat,
                     logic [W-1:0] es, logic ec, logic eo, logic ez, logic en);
    exp_t e;
    e = {es, ec, eo, ez, en};
    chk({nm, "_model_pin"}, 32'(model(a, b, sub, sat)), 32'(e));
    bus.a = a; bus.b = b; bus.sub = sub; bus.sat = sat;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_accept"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_lat2_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_result"}, 32'(dut_out()), 32'(e));
    @(posedge clk); #1;
  endtask

  task automatic push_beat(logic [W-1:0] a, logic [W-1:0] b, logic sub);
    bus.a = a; bus.b = b; bus.sub = sub; bus.sat = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("push_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // mode 0: out_ready high, 1: alternating 1,0,..., 2: random valid and ready
  task automatic stream(int n, int mode);
    int sent = 0;
    int cyc  = 0;
    bit have = 0;
    bit acc;
    while ((sent < n || q.size() != 0) && cyc < 20 * n + 50) begin
      if (sent < n && !have) begin
        bus.a = rnd_op(); bus.b = rnd_op();
        bus.sub = 1'($urandom); bus.sat = 1'($urandom);
        have = 1;
      end
      bus.in_valid  = have && (mode != 2 || $urandom_range(0, 3) != 0);
      bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin sent++; have = 0; end
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("stream_sent", 32'(sent), 32'(n));
    chk("stream_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.sat = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_outputs", 32'(dut_out()), 32'd0);
    @(posedge clk); #1;

    one("t1_add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    one("t1_add_sat",   16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    one("t2_sub_borrow",16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    one("t2_sub_pos",   16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    one("t3_wrap_zero", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    one("t3_sub_sat",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);

    // Stall with both stages full: outputs hold and input side closes.
    bus.out_ready = 1'b0;
    push_beat(16'h1234, 16'h1111, 1'b0);
    push_beat(16'h0001, 16'h0002, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_sum", 32'(bus.sum), 32'h2345);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("drain_first", 32'(dut_out()), 32'({16'h2345, 1'b0, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    chk("drain_second", 32'(dut_out()), 32'({16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1}));
    @(negedge clk);
    chk("drain_empty", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // Reset with two beats in flight.
    bus.out_ready = 1'b0;
    push_beat(16'h0F0F, 16'h0101, 1'b0);
    push_beat(16'h4000, 16'h4000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_outputs", 32'(dut_out()), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end

    stream(8, 1);
    stream(200, 0);
    stream(2000, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
